level_timer_ctl: RTL

- Sequences play inside a level: "3-2-1" countdown, then enables player movement, then runs a seconds timer until both players finish or the time limit expires.
- Keeps the best (lowest) completion time since reset.
- Sits between the game state machine (level-active indication) and the player controllers (move enable) and overlay renderer (countdown/timer digits).

---
 rtl/level_timer_ctl.sv | 117 +++++++++++
 1 files changed

// File: rtl/level_timer_ctl.sv
// level_timer_ctl: level countdown, move enable, BCD seconds timer, timeout and best-time tracking.
module level_timer_ctl #(
    parameter int TICK_DIV     = 40000000,
    parameter int COUNTDOWN_S  = 3,
    parameter int TIME_LIMIT_S = 99
) (
    input  logic       clk_40,
    input  logic       rst_n,
    input  logic       level_active,
    input  logic       finish_p1,
    input  logic       finish_p2,
    output logic       move_en,
    output logic [1:0] countdown,
    output logic [7:0] timer_bcd,
    output logic       timeout,
    output logic       level_done,
    output logic [7:0] best_bcd,
    output logic       best_valid
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [7:0] LIMIT_BCD = 8'((TIME_LIMIT_S / 10) * 16 + TIME_LIMIT_S % 10);

    typedef enum logic [2:0] {IDLE, COUNTDOWN, RUN, FINISHED, TIMEOUT} state_t;

    state_t        state, state_n;
    logic [PW-1:0] presc, presc_n;
    logic          la_q, tick, rise;
    logic [7:0]    tmr_inc, tmr_n, best_n;
    logic [1:0]    cd_n;
    logic          move_n, to_n, done_n, bv_n;

    assign tick    = presc == PW'(TICK_DIV - 1);
    assign rise    = level_active & ~la_q;
    assign tmr_inc = timer_bcd[3:0] == 4'd9 ? {timer_bcd[7:4] + 4'd1, 4'd0}
                                            : {timer_bcd[7:4], timer_bcd[3:0] + 4'd1};

    always_comb begin
        state_n = state;
        presc_n = tick ? '0 : presc + 1'b1;
        move_n  = move_en;
        cd_n    = countdown;
        tmr_n   = timer_bcd;
        to_n    = timeout;
        done_n  = 1'b0;
        best_n  = best_bcd;
        bv_n    = best_valid;
        // Losing the level outranks tick and finish in every active state.
        if (state != IDLE && !level_active) begin
            state_n = IDLE;
            move_n  = 1'b0;
            cd_n    = 2'd0;
            to_n    = 1'b0;
        end else begin
            case (state)
                IDLE: if (rise) begin
                    state_n = COUNTDOWN;
                    cd_n    = 2'(COUNTDOWN_S);
                    tmr_n   = 8'h00;
                    presc_n = '0;
                end
                COUNTDOWN: if (tick) begin
                    if (countdown > 2'd1) begin
                        cd_n = countdown - 2'd1;
                    end else begin
                        state_n = RUN;
                        cd_n    = 2'd0;
                        move_n  = 1'b1;
                        presc_n = '0;
                    end
                end
                RUN: if (finish_p1 && finish_p2) begin
                    state_n = FINISHED;
                    move_n  = 1'b0;
                    done_n  = 1'b1;
                    if (!best_valid || timer_bcd < best_bcd) begin
                        best_n = timer_bcd;
                        bv_n   = 1'b1;
                    end
                end else if (tick) begin
                    tmr_n = tmr_inc;
                    if (tmr_inc == LIMIT_BCD) begin
                        state_n = TIMEOUT;
                        to_n    = 1'b1;
                        move_n  = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_40) begin
        if (!rst_n) begin
            state      <= IDLE;
            presc      <= '0;
            la_q       <= 1'b0;
            move_en    <= 1'b0;
            countdown  <= 2'd0;
            timer_bcd  <= 8'h00;
            timeout    <= 1'b0;
            level_done <= 1'b0;
            best_bcd   <= 8'h00;
            best_valid <= 1'b0;
        end else begin
            state      <= state_n;
            presc      <= presc_n;
            la_q       <= level_active;
            move_en    <= move_n;
            countdown  <= cd_n;
            timer_bcd  <= tmr_n;
            timeout    <= to_n;
            level_done <= done_n;
            best_bcd   <= best_n;
            best_valid <= bv_n;
        end
    end
endmodule
